// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - digit-serial WIDTH-bit adder/subtractor with start/done handshake
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             zero_o
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [CW-1:0]    cnt_q;
    logic             cy_q, op_q, sign_a_q, sign_b_q;
    logic             busy_q, done_q, carry_q, overflow_q, zero_q;
    logic [WIDTH-1:0] result_q;

    logic [DIGIT:0]   sum_d;
    logic [WIDTH-1:0] res_d;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state: start is only honoured outside RUN, so DONE can chain straight into RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: state_d = start_i ? S_RUN : S_IDLE;
            S_RUN:          if (cnt_q == LAST) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    // One digit of the sum, and the result shift register with that digit shifted in at the top
    always_comb begin
        sum_d = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, cy_q};
        res_d = WIDTH'({sum_d[DIGIT-1:0], res_q} >> DIGIT);
    end

    // Operand capture, digit iteration and output register load on the final digit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            cy_q       <= 1'b0;
            op_q       <= 1'b0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            busy_q <= (state_d == S_RUN);
            done_q <= (state_d == S_DONE);
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        // Subtract as a + ~b + 1; signs kept because the operands get shifted away
                        a_q      <= a_i;
                        b_q      <= b_i ^ {WIDTH{op_i}};
                        cy_q     <= op_i;
                        op_q     <= op_i;
                        cnt_q    <= '0;
                        sign_a_q <= a_i[WIDTH-1];
                        sign_b_q <= b_i[WIDTH-1] ^ op_i;
                    end
                end
                S_RUN: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    res_q <= res_d;
                    cy_q  <= sum_d[DIGIT];
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        // Carry out of a subtract is the inverse of borrow
                        result_q   <= res_d;
                        carry_q    <= sum_d[DIGIT] ^ op_q;
                        zero_q     <= (res_d == '0);
                        overflow_q <= (sign_a_q == sign_b_q) && (res_d[WIDTH-1] != sign_a_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign carry_o    = carry_q;
    assign overflow_o = overflow_q;
    assign zero_o     = zero_q;

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised multi-cycle adder/subtractor that computes `a + b` or `a - b` on WIDTH-bit operands, DIGIT bits per clock, with a start/done handshake and registered result flags. It generalises the team's 8-bit combinational subtractor into a sequential unit for the datapath and ALU labs. It trades latency for a narrow DIGIT-bit adder and reports carry/borrow, signed overflow and zero alongside the result.

## Interface
- WIDTH, 16, operand and result width in bits; ≥ 2.
- DIGIT, 4, bits processed per cycle; must divide WIDTH exactly. N = WIDTH/DIGIT is the number of compute cycles.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy = 0.
- op  input  1  0 = add, 1 = subtract; sampled with start.
- a  input  WIDTH  minuend/augend; sampled with start.
- b  input  WIDTH  subtrahend/addend; sampled with start.
- busy  output  1  high while computing.
- done  output  1  one-cycle pulse when result and flags update.
- result  output  WIDTH  `a + b` or `a - b`, mod 2^WIDTH.
- carry  output  1  add: carry out of MSB. Sub: borrow, set when unsigned a < b.
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  result == 0.

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE; busy, done, result, carry, overflow, zero all 0; internal counter, shift registers and carry cleared.
- IDLE or DONE with start = 1:
  - latch a, and b XOR {WIDTH{op}};
  - carry-in = op;
  - digit counter = 0;
  - go to RUN.
- start while in RUN is ignored; operands are not re-sampled.
- RUN, each cycle:
  - add the low DIGIT bits of the latched a and b plus the running carry;
  - shift the DIGIT-bit sum into the top of the result shift register;
  - shift both operand registers right by DIGIT;
  - keep the carry-out for the next digit;
  - increment the counter.
- After N RUN cycles go to DONE.
- Entering DONE loads the output registers:
  - result ← shift register;
  - carry ← final carry-out XOR op;
  - overflow ← (sign of a == sign of effective b) AND (sign of result ≠ sign of a), using the latched, possibly inverted, b;
  - zero ← (result == 0).
- DONE lasts one cycle with done = 1. Without start it returns to IDLE; with start it goes straight to RUN (back-to-back operation).
- result and flags hold their values from one done until the next done. They do not change during RUN.
- rst during RUN or DONE aborts the operation and applies the reset values. No done is produced for the aborted operation.
- If DIGIT = WIDTH, then N = 1 and the unit degenerates to a single RUN cycle.

## Timing
- Let cycle 0 be the cycle in which start = 1 is sampled while busy = 0.
- busy = 1 in cycles 1..N and 0 otherwise, including the DONE cycle.
- done = 1 in cycle N+1 only. result and flags are valid from cycle N+1.
- Latency from start to done is N+1 cycles. With back-to-back starts, throughput is one operation per N+1 cycles.
- A start asserted in cycle N+1 (the done cycle) gives busy = 1 in cycle N+2.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use WIDTH = 16, DIGIT = 4 (N = 4) unless stated otherwise.
- Add and latency: add 0x1234 + 0x0FFF, start in cycle 0 → busy in cycles 1–4, done only in cycle 5, result 0x2233, carry 0, overflow 0, zero 0.
- Borrow:
  - sub 0x0005 − 0x0007 → result 0xFFFE, carry (borrow) 1, overflow 0;
  - sub 0xA5A5 − 0xA5A5 → result 0x0000, zero 1, carry 0.
- Signed overflow:
  - add 0x7FFF + 0x0001 → result 0x8000, overflow 1, carry 0;
  - sub 0x8000 − 0x0001 → result 0x7FFF, overflow 1, carry 0;
  - add 0xFFFF + 0x0001 → result 0x0000, carry 1, zero 1, overflow 0.
- Handshake:
  - start pulsed in cycle 2 of a RUN with different operands → ignored, first result unchanged;
  - start held high through the done cycle → second operation begins, busy in the next cycle, second done exactly N+1 cycles after the first.
- Reset mid-op: rst in cycle 2 of RUN → next cycle all outputs 0, state IDLE, no done pulse; a fresh start afterwards completes normally.
- Degenerate configuration: WIDTH = 8, DIGIT = 8, sub 0x12 − 0x34 → done in cycle 2, result 0xDE, carry 1, overflow 0.
